// File: rtl/rom_stream_loader_pkg.sv
// Shared types and constants for the ROM stream loader.
package rom_stream_loader_pkg;

   // One stream byte per lane, four lanes per ROM word.
   localparam int unsigned LANE_W = 8;
   localparam int unsigned LANES  = 4;

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StDone,
      StErr
   } state_e;

   // ROM size in bytes for a given byte-address width.
   function automatic int unsigned rom_byte_size(input int unsigned addr_width);
      return 32'd1 << addr_width;
   endfunction

   // ROM depth in 32-bit words for a given byte-address width.
   function automatic int unsigned rom_depth(input int unsigned addr_width);
      return 32'd1 << (addr_width - 32'd2);
   endfunction

endpackage

// File: rtl/rom_stream_loader_packer.sv
// Lane-indexed 4-byte word buffer. The merged word (buffer plus incoming byte) is
// presented combinationally so the caller can register it on the flush cycle.
module rom_byte_packer
   import rom_stream_loader_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clear_i,
   input  logic                      wr_en_i,
   input  logic                      flush_i,
   input  logic [1:0]                lane_i,
   input  logic [LANE_W-1:0]         data_i,
   output logic [LANE_W*LANES-1:0]   word_o,
   output logic                      word_valid_o
);

   logic [LANE_W*LANES-1:0] pack_q;

   // Current buffer with the incoming byte dropped into its lane.
   always_comb begin
      word_o = pack_q;
      word_o[LANE_W*lane_i +: LANE_W] = data_i;
   end

   assign word_valid_o = wr_en_i & flush_i;

   // Accumulate bytes; a flush empties the buffer so unwritten lanes of the next word are zero.
   always_ff @(posedge clk) begin
      if (rst || clear_i) begin
         pack_q <= '0;
      end else if (wr_en_i) begin
         if (flush_i) begin
            pack_q <= '0;
         end else begin
            pack_q[LANE_W*lane_i +: LANE_W] <= data_i;
         end
      end
   end

endmodule

// File: rtl/rom_stream_loader.sv
// Packs a byte stream little-endian into 32-bit words and writes them to the instruction
// ROM from word 0 upward, holding the CPU in reset until the image is complete.
module rom_stream_loader
   import rom_stream_loader_pkg::*;
#(
   parameter int unsigned ROM_ADDR_WIDTH = 14,
   parameter bit          HOLD_AT_RESET  = 1'b1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start_i,
   input  logic [ROM_ADDR_WIDTH:0]   len_i,
   input  logic                      byte_valid_i,
   input  logic [7:0]                byte_data_i,
   output logic                      byte_ready_o,
   output logic                      rom_we_o,
   output logic [ROM_ADDR_WIDTH-3:0] rom_addr_o,
   output logic [31:0]               rom_wdata_o,
   output logic                      busy_o,
   output logic                      done_o,
   output logic                      err_o,
   output logic                      cpu_hold_o
);

   localparam int unsigned RomBytes = rom_byte_size(ROM_ADDR_WIDTH);

   state_e                  state_q;
   logic [ROM_ADDR_WIDTH:0] byte_cnt_q;
   logic [ROM_ADDR_WIDTH:0] len_q;

   logic        accept;
   logic        last_byte;
   logic        restart;
   logic [31:0] word;
   logic        word_valid;

   // byte_ready_o is only ever high in LOAD, so it alone qualifies the handshake.
   assign accept    = byte_valid_i & byte_ready_o;
   assign last_byte = (byte_cnt_q == len_q - 1'b1);
   // start_i is honoured everywhere except mid-load.
   assign restart   = start_i & (state_q != StLoad);

   rom_byte_packer u_packer (
      .clk          (clk),
      .rst          (rst),
      .clear_i      (restart),
      .wr_en_i      (accept),
      .flush_i      ((byte_cnt_q[1:0] == 2'd3) | last_byte),
      .lane_i       (byte_cnt_q[1:0]),
      .data_i       (byte_data_i),
      .word_o       (word),
      .word_valid_o (word_valid)
   );

   // Load FSM with byte counter and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         byte_cnt_q   <= '0;
         len_q        <= '0;
         byte_ready_o <= 1'b0;
         rom_we_o     <= 1'b0;
         rom_addr_o   <= '0;
         rom_wdata_o  <= '0;
         busy_o       <= 1'b0;
         done_o       <= 1'b0;
         err_o        <= 1'b0;
         cpu_hold_o   <= HOLD_AT_RESET;
      end else begin
         rom_we_o <= 1'b0;
         unique case (state_q)
            StIdle, StDone, StErr: begin
               // The final write pulse is in the first DONE cycle; release the CPU after it.
               if (state_q == StDone) begin
                  cpu_hold_o <= 1'b0;
               end
               if (restart) begin
                  len_q      <= len_i;
                  byte_cnt_q <= '0;
                  done_o     <= 1'b0;
                  err_o      <= 1'b0;
                  cpu_hold_o <= 1'b1;
                  if (32'(len_i) > RomBytes) begin
                     state_q <= StErr;
                     done_o  <= 1'b1;
                     err_o   <= 1'b1;
                  end else if (len_i == '0) begin
                     state_q <= StDone;
                     done_o  <= 1'b1;
                  end else begin
                     state_q      <= StLoad;
                     busy_o       <= 1'b1;
                     byte_ready_o <= 1'b1;
                  end
               end
            end
            StLoad: begin
               if (accept) begin
                  byte_cnt_q <= byte_cnt_q + 1'b1;
                  if (word_valid) begin
                     rom_we_o    <= 1'b1;
                     rom_addr_o  <= byte_cnt_q[ROM_ADDR_WIDTH-1:2];
                     rom_wdata_o <= word;
                  end
                  if (last_byte) begin
                     state_q      <= StDone;
                     busy_o       <= 1'b0;
                     byte_ready_o <= 1'b0;
                     done_o       <= 1'b1;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_rom_stream_loader.sv
// Directed and randomized checks of rom_stream_loader against a word-level image model.
module tb_rom_stream_loader;

   localparam int unsigned AW = 14;
   localparam int unsigned ROM_BYTES = 1 << AW;

   logic          clk = 1'b0;
   logic          rst;
   logic          start_i;
   logic [AW:0]   len_i;
   logic          byte_valid_i;
   logic [7:0]    byte_data_i;
   logic          byte_ready_o;
   logic          rom_we_o;
   logic [AW-3:0] rom_addr_o;
   logic [31:0]   rom_wdata_o;
   logic          busy_o;
   logic          done_o;
   logic          err_o;
   logic          cpu_hold_o;

   int nvec = 0;
   int nerr = 0;
   int cyc  = 0;

   logic [7:0] img [$];
   int         exp_cyc [$];
   int         wr_addr [$];
   logic [31:0] wr_data [$];
   int         wr_cyc [$];
   logic       hold_log [int];

   rom_stream_loader #(
      .ROM_ADDR_WIDTH (AW),
      .HOLD_AT_RESET  (1'b1)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start_i      (start_i),
      .len_i        (len_i),
      .byte_valid_i (byte_valid_i),
      .byte_data_i  (byte_data_i),
      .byte_ready_o (byte_ready_o),
      .rom_we_o     (rom_we_o),
      .rom_addr_o   (rom_addr_o),
      .rom_wdata_o  (rom_wdata_o),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .err_o        (err_o),
      .cpu_hold_o   (cpu_hold_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Capture ROM writes and hold level once per cycle, away from the active edge.
   always @(negedge clk) begin
      hold_log[cyc] = cpu_hold_o;
      if (rom_we_o === 1'b1) begin
         wr_addr.push_back(int'(rom_addr_o));
         wr_data.push_back(rom_wdata_o);
         wr_cyc.push_back(cyc);
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
         $error("miscompare in %s", tag);
      end
   endtask

   task automatic chk_reset_values();
      chk("rst_ready", 64'(byte_ready_o), 64'd0);
      chk("rst_we", 64'(rom_we_o), 64'd0);
      chk("rst_addr", 64'(rom_addr_o), 64'd0);
      chk("rst_wdata", 64'(rom_wdata_o), 64'd0);
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_done", 64'(done_o), 64'd0);
      chk("rst_err", 64'(err_o), 64'd0);
      chk("rst_hold", 64'(cpu_hold_o), 64'd1);
   endtask

   // Entered and left at a negedge.
   task automatic start_load(input int n);
      wr_addr.delete();
      wr_data.delete();
      wr_cyc.delete();
      exp_cyc.delete();
      start_i = 1'b1;
      len_i   = (AW + 1)'(n);
      @(negedge clk);
      start_i = 1'b0;
      if (n >= 1 && n <= int'(ROM_BYTES)) begin
         chk("start_busy", 64'(busy_o), 64'd1);
         chk("start_ready", 64'(byte_ready_o), 64'd1);
         chk("start_done_clr", 64'(done_o), 64'd0);
         chk("start_hold", 64'(cpu_hold_o), 64'd1);
      end
   endtask

   // Offer bytes img[0..n_feed-1] of an n-byte image; expect a write one cycle after each
   // lane-3 or final byte is accepted.
   task automatic feed(input int n, input int n_feed, input int gap_pct, input bit mid_start);
      int idx = 0;
      int guard = 0;
      bit pulsed = 1'b0;
      while (idx < n_feed && guard < 40 * n_feed + 20) begin
         start_i = 1'b0;
         if (int'($urandom_range(99)) < gap_pct) begin
            byte_valid_i = 1'b0;
            byte_data_i  = 8'($urandom);
         end else begin
            byte_valid_i = 1'b1;
            byte_data_i  = img[idx];
         end
         if (mid_start && idx == 3 && !pulsed) begin
            start_i = 1'b1;
            len_i   = (AW + 1)'(4);
            pulsed  = 1'b1;
         end
         if (byte_valid_i && byte_ready_o === 1'b1) begin
            if (idx % 4 == 3 || idx == n - 1) exp_cyc.push_back(cyc + 1);
            idx++;
         end
         @(negedge clk);
         guard++;
      end
      start_i      = 1'b0;
      byte_valid_i = 1'b0;
      chk("feed_count", 64'(idx), 64'(n_feed));
   endtask

   // Compare captured writes with the image packed into little-endian words.
   task automatic verify_image(input int n);
      int nw;
      logic [31:0] w;
      repeat (3) @(negedge clk);
      nw = (n + 3) / 4;
      chk("num_writes", 64'(wr_addr.size()), 64'(nw));
      for (int i = 0; i < nw && i < wr_addr.size(); i++) begin
         w = '0;
         for (int k = 0; k < 4; k++) begin
            if (4 * i + k < n) w = w | (32'(img[4 * i + k]) << (8 * k));
         end
         chk($sformatf("addr%0d", i), 64'(wr_addr[i]), 64'(i));
         chk($sformatf("data%0d", i), 64'(wr_data[i]), 64'(w));
         if (i < exp_cyc.size()) chk($sformatf("lat%0d", i), 64'(wr_cyc[i]), 64'(exp_cyc[i]));
      end
      chk("end_done", 64'(done_o), 64'd1);
      chk("end_busy", 64'(busy_o), 64'd0);
      chk("end_ready", 64'(byte_ready_o), 64'd0);
      chk("end_err", 64'(err_o), 64'd0);
      if (wr_cyc.size() > 0) begin
         chk("hold_at_last_wr", 64'(hold_log[wr_cyc[$]]), 64'd1);
         chk("hold_after_last_wr", 64'(hold_log[wr_cyc[$] + 1]), 64'd0);
      end
   endtask

   initial begin
      int n;
      int waited;
      rst          = 1'b1;
      start_i      = 1'b0;
      len_i        = '0;
      byte_valid_i = 1'b0;
      byte_data_i  = '0;
      repeat (2) @(negedge clk);
      chk_reset_values();
      rst = 1'b0;
      @(negedge clk);

      // Two full words, no gaps.
      img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      start_load(8);
      feed(8, 8, 0, 1'b0);
      verify_image(8);

      // Partial final word with random gaps.
      img = '{8'h6F, 8'h00, 8'h00, 8'h00, 8'hAB};
      start_load(5);
      feed(5, 5, 40, 1'b0);
      verify_image(5);

      // Zero length: straight to done, no writes, CPU released.
      start_load(0);
      chk("len0_done", 64'(done_o), 64'd1);
      chk("len0_busy", 64'(busy_o), 64'd0);
      waited = 0;
      while (cpu_hold_o !== 1'b0 && waited < 3) begin
         @(negedge clk);
         waited++;
      end
      chk("len0_hold_released", 64'(cpu_hold_o), 64'd0);
      chk("len0_writes", 64'(wr_addr.size()), 64'd0);

      // Oversized image: error, no writes, CPU kept in reset, bytes refused.
      start_load(int'(ROM_BYTES) + 1);
      chk("err_err", 64'(err_o), 64'd1);
      chk("err_done", 64'(done_o), 64'd1);
      chk("err_ready", 64'(byte_ready_o), 64'd0);
      byte_valid_i = 1'b1;
      byte_data_i  = 8'h5A;
      repeat (4) @(negedge clk);
      byte_valid_i = 1'b0;
      chk("err_hold", 64'(cpu_hold_o), 64'd1);
      chk("err_writes", 64'(wr_addr.size()), 64'd0);

      // Restart from ERR; a start pulse mid-load must be ignored.
      img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      start_load(8);
      feed(8, 8, 0, 1'b1);
      verify_image(8);

      // Reset after 6 of 8 bytes: only word 0 written, outputs back to reset values.
      img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      start_load(8);
      feed(8, 6, 0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_reset_values();
      byte_valid_i = 1'b1;
      repeat (3) @(negedge clk);
      byte_valid_i = 1'b0;
      chk("rst_mid_writes", 64'(wr_addr.size()), 64'd1);
      if (wr_data.size() > 0) chk("rst_mid_data0", 64'(wr_data[0]), 64'h44332211);

      // Fresh 4-byte load writes word 0 again.
      img = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      start_load(4);
      feed(4, 4, 0, 1'b0);
      verify_image(4);

      // Exactly full ROM size is legal: loading starts, then abort via reset.
      start_load(int'(ROM_BYTES));
      chk("full_err", 64'(err_o), 64'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_reset_values();

      // Random images with random gaps.
      for (int t = 0; t < 6; t++) begin
         n = int'($urandom_range(1, 23));
         img.delete();
         for (int i = 0; i < n; i++) img.push_back(8'($urandom));
         start_load(n);
         feed(n, n, 30, 1'b0);
         verify_image(n);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
